// File: rtl/sprite_ram_ctrl_if.sv
// rtl/sprite_ram_ctrl_if.sv - video, host, fill and RAM-port signals of the sprite RAM controller
interface sprite_ram_ctrl_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
);
    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic [DATA_WIDTH-1:0] vid_data;
    logic                  vid_valid;
    logic                  hr_req;
    logic [ADDR_WIDTH-1:0] hr_addr;
    logic [DATA_WIDTH-1:0] hr_rdata;
    logic                  hr_ack;
    logic                  hr_starved;
    logic                  hw_req;
    logic [ADDR_WIDTH-1:0] hw_addr;
    logic [DATA_WIDTH-1:0] hw_data;
    logic                  fill_start;
    logic [DATA_WIDTH-1:0] fill_value;
    logic                  fill_busy;
    logic                  fill_done;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr_w;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        output vid_req, vid_addr, hr_req, hr_addr, hw_req, hw_addr, hw_data,
               fill_start, fill_value, ram_dout,
        input  vid_data, vid_valid, hr_rdata, hr_ack, hr_starved, fill_busy, fill_done,
               ram_we, ram_addr_w, ram_din, ram_addr_r
    );

    modport slave (
        input  vid_req, vid_addr, hr_req, hr_addr, hw_req, hw_addr, hw_data,
               fill_start, fill_value, ram_dout,
        output vid_data, vid_valid, hr_rdata, hr_ack, hr_starved, fill_busy, fill_done,
               ram_we, ram_addr_w, ram_din, ram_addr_r
    );
endinterface

// File: rtl/sprite_ram_ctrl.sv
// rtl/sprite_ram_ctrl.sv - sprite RAM port sharing: video/host reads, host/fill writes (SPRITE_RAM_FILL_EN enables fill)
module sprite_ram_ctrl #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    sprite_ram_ctrl_if.slave  bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    rd_state_t             rd_state;
    logic [CW-1:0]         starve_cnt;
    logic [CW-1:0]         starve_inc;
    logic                  vid_valid_q;
    logic                  hr_ack_q;
    logic                  hr_starved_q;
    logic [DATA_WIDTH-1:0] hr_hold;

    assign starve_inc = (starve_cnt >= CW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + CW'(1);

    // Video always wins the read port; host reads take leftover slots.
    assign bus.ram_addr_r = bus.vid_req ? bus.vid_addr : bus.hr_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state     <= RD_IDLE;
            starve_cnt   <= '0;
            vid_valid_q  <= 1'b0;
            hr_ack_q     <= 1'b0;
            hr_starved_q <= 1'b0;
            hr_hold      <= '0;
        end else begin
            vid_valid_q <= bus.vid_req;
            case (rd_state)
                RD_IDLE: begin
                    if (bus.hr_req && !bus.vid_req) begin
                        rd_state     <= RD_DATA;
                        hr_ack_q     <= 1'b1;
                        hr_starved_q <= 1'b0;
                        starve_cnt   <= '0;
                    end else if (bus.hr_req) begin
                        starve_cnt <= starve_inc;
                        if (starve_inc >= CW'(STARVE_LIMIT))
                            hr_starved_q <= 1'b1;
                    end
                end
                RD_DATA: begin
                    rd_state   <= RD_IDLE;
                    hr_ack_q   <= 1'b0;
                    hr_hold    <= bus.ram_dout;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.vid_valid  = vid_valid_q;
    assign bus.vid_data   = vid_valid_q ? bus.ram_dout : '0;
    assign bus.hr_ack     = hr_ack_q;
    assign bus.hr_rdata   = hr_ack_q ? bus.ram_dout : hr_hold;
    assign bus.hr_starved = hr_starved_q;

    logic                  fill_wr;
    logic [ADDR_WIDTH-1:0] fill_wr_addr;
    logic [DATA_WIDTH-1:0] fill_wr_data;

`ifdef SPRITE_RAM_FILL_EN
    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

    fill_state_t           fill_state;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_val;
    logic                  fill_busy_q;
    logic                  fill_done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_state  <= IDLE;
            fill_addr   <= '0;
            fill_val    <= '0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            case (fill_state)
                IDLE: begin
                    if (bus.fill_start) begin
                        fill_state  <= FILL;
                        fill_addr   <= '0;
                        fill_val    <= bus.fill_value;
                        fill_busy_q <= 1'b1;
                    end
                end
                FILL: begin
                    // Host writes steal the port; the fill pointer just waits.
                    if (!bus.hw_req) begin
                        fill_addr <= fill_addr + ADDR_WIDTH'(1);
                        if (&fill_addr) begin
                            fill_state  <= DONE;
                            fill_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    fill_state  <= IDLE;
                    fill_busy_q <= 1'b0;
                    fill_done_q <= 1'b0;
                end
                default: fill_state <= IDLE;
            endcase
        end
    end

    assign fill_wr       = (fill_state == FILL);
    assign fill_wr_addr  = fill_addr;
    assign fill_wr_data  = fill_val;
    assign bus.fill_busy = fill_busy_q;
    assign bus.fill_done = fill_done_q;
`else
    logic unused_fill;
    assign unused_fill   = ^{bus.fill_start, bus.fill_value};
    assign fill_wr       = 1'b0;
    assign fill_wr_addr  = '0;
    assign fill_wr_data  = '0;
    assign bus.fill_busy = 1'b0;
    assign bus.fill_done = 1'b0;
`endif

    always_comb begin
        bus.ram_we     = 1'b0;
        bus.ram_addr_w = '0;
        bus.ram_din    = '0;
        if (bus.hw_req) begin
            bus.ram_we     = 1'b1;
            bus.ram_addr_w = bus.hw_addr;
            bus.ram_din    = bus.hw_data;
        end else if (fill_wr) begin
            bus.ram_we     = 1'b1;
            bus.ram_addr_w = fill_wr_addr;
            bus.ram_din    = fill_wr_data;
        end
    end
endmodule

// File: tb/tb_sprite_ram_ctrl.sv
// tb/tb_sprite_ram_ctrl.sv - randomized bench for sprite_ram_ctrl against a shadow-memory model
module tb_sprite_ram_ctrl;
    localparam int DW    = 12;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;
    localparam int SL    = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sprite_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sprite_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Simple-dual-port RAM: registered read, read-before-write on collision.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
            ram_loaded <= 1'b1;
        end else begin
            if (bus.ram_we) ram[bus.ram_addr_w] <= bus.ram_din;
        end
        bus.ram_dout <= ram[bus.ram_addr_r];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic          exp_vv, exp_ack, exp_starved;
    logic [DW-1:0] exp_vd, exp_hrd;
    logic          host_pend, in_ack;
    int            denied;
    int            f_state, f_ptr;
    logic [DW-1:0] f_val;
    int            cyc;

    task automatic model_reset();
        exp_vv = 0; exp_ack = 0; exp_starved = 0; exp_vd = '0; exp_hrd = '0;
        host_pend = 0; in_ack = 0; denied = 0; f_state = 0; f_ptr = 0; f_val = '0;
    endtask

    task automatic drive_idle();
        bus.vid_req = 0; bus.vid_addr = '0; bus.hr_req = 0; bus.hr_addr = '0;
        bus.hw_req = 0; bus.hw_addr = '0; bus.hw_data = '0;
        bus.fill_start = 0; bus.fill_value = '0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_vid_valid"}, bus.vid_valid, 0);
        check({tag, "_vid_data"}, bus.vid_data, 0);
        check({tag, "_hr_ack"}, bus.hr_ack, 0);
        check({tag, "_hr_rdata"}, bus.hr_rdata, 0);
        check({tag, "_hr_starved"}, bus.hr_starved, 0);
        check({tag, "_fill_busy"}, bus.fill_busy, 0);
        check({tag, "_fill_done"}, bus.fill_done, 0);
        check({tag, "_ram_we"}, bus.ram_we, 0);
    endtask

    task automatic run_cycles(input int n);
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int            seg;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            check("vid_valid", bus.vid_valid, exp_vv);
            if (exp_vv) check("vid_data", bus.vid_data, exp_vd);
            check("hr_ack", bus.hr_ack, exp_ack);
            check("hr_rdata", bus.hr_rdata, exp_hrd);
            check("hr_starved", bus.hr_starved, exp_starved);
            check("fill_busy", bus.fill_busy, f_state != 0);
            check("fill_done", bus.fill_done, f_state == 2);

            seg = (cyc / 48) % 3;
            bus.vid_req    = (seg == 1) ? 1'b1 : (seg == 0) ? 1'($urandom % 2) : 1'($urandom % 10 == 0);
            bus.vid_addr   = AW'($urandom);
            if (!host_pend) begin
                bus.hr_req = ($urandom % 3 == 0);
                bus.hr_addr = AW'($urandom);
                host_pend = bus.hr_req;
            end
            bus.hw_req     = ($urandom % 4 == 0);
            bus.hw_addr    = AW'($urandom);
            bus.hw_data    = DW'($urandom);
            bus.fill_start = ($urandom % 120 == 0);
            bus.fill_value = DW'($urandom);
            #1;

            ew = 0; ea = '0; ed = '0;
            if (bus.hw_req) begin
                ew = 1; ea = bus.hw_addr; ed = bus.hw_data;
            end else if (f_state == 1) begin
                ew = 1; ea = AW'(f_ptr); ed = f_val;
            end
            check("ram_we", bus.ram_we, ew);
            if (ew) begin
                check("ram_addr_w", bus.ram_addr_w, ea);
                check("ram_din", bus.ram_din, ed);
            end
            check("ram_addr_r", bus.ram_addr_r, bus.vid_req ? bus.vid_addr : bus.hr_addr);

            // Reads see memory before this cycle's write.
            exp_vv = bus.vid_req;
            exp_vd = ref_mem[bus.vid_addr];
            if (in_ack) begin
                in_ack = 0; host_pend = 0; exp_ack = 0; denied = 0;
            end else if (bus.hr_req && !bus.vid_req) begin
                exp_ack = 1; exp_hrd = ref_mem[bus.hr_addr];
                denied = 0; exp_starved = 0; in_ack = 1;
            end else begin
                exp_ack = 0;
                if (bus.hr_req) begin
                    denied++;
                    if (denied >= SL) exp_starved = 1;
                end
            end
            if (ew) ref_mem[ea] = ed;
`ifdef SPRITE_RAM_FILL_EN
            case (f_state)
                0: if (bus.fill_start) begin f_state = 1; f_ptr = 0; f_val = bus.fill_value; end
                1: if (!bus.hw_req) begin
                       if (f_ptr == DEPTH - 1) f_state = 2;
                       else f_ptr++;
                   end
                default: f_state = 0;
            endcase
`endif
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom);
        cyc = 0;
        model_reset();
        drive_idle();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1;

        run_cycles(1500);

        // Asynchronous reset in the middle of a cycle, mid-stream.
        @(negedge clk);
        drive_idle();
        #2;
        reset_n = 0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk); #1;
        check_outputs_zero("held_reset");
        @(negedge clk);
        reset_n = 1;
        model_reset();

        run_cycles(1500);

        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) check("mem_final", ram[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
